// File: rtl/dram_arbiter_pkg.sv
// Shared types and sizing helpers for the multi-core data DRAM arbiter.
package dram_arb_pkg;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Index width for a set of n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Core-side request bus and shared DRAM port seen by the arbiter.
interface dram_arb_if
    import dram_arb_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
);
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_we;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_gnt;
    logic [DATA_W-1:0]           core_rdata;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_we;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        busy;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, mem_rdata,
        output core_gnt, core_rdata, mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, mem_rdata,
        input  core_gnt, core_rdata, mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_picker
    import dram_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_CORES,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] pos_s;
    logic          hit_s;

    // Scan priority order ptr, ptr+1, ... and keep only the first hit.
    always_comb begin
        winner = '0;
        idx    = '0;
        valid  = 1'b0;
        pos_s  = '0;
        hit_s  = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos_s         = IW'((int'(ptr) + i) % N);
            hit_s         = req[pos_s] & ~valid;
            winner[pos_s] = winner[pos_s] | hit_s;
            idx           = hit_s ? pos_s : idx;
            valid         = valid | hit_s;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port data DRAM between NUM_CORES cores.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = 2
) (
    input  logic      clk,
    input  logic      rst,
    dram_arb_if.slave bus
);

    localparam int IW = idx_width(NUM_CORES);
    localparam int CW = idx_width(RD_LAT + 1);

    state_t                 state_r;
    logic [IW-1:0]          ptr_r;
    logic [IW-1:0]          owner_r;
    logic [NUM_CORES-1:0]   owner_oh_r;
    logic [CW-1:0]          cnt_r;
    logic [NUM_CORES-1:0]   gnt_r;
    logic [DATA_W-1:0]      rdata_r;
    logic [ADDR_W-1:0]      mem_addr_r;
    logic [DATA_W-1:0]      mem_wdata_r;
    logic                   mem_we_r;
    logic                   busy_r;

    logic [NUM_CORES-1:0]   win_oh_s;
    logic [IW-1:0]          win_idx_s;
    logic                   win_valid_s;

    rr_picker #(.N(NUM_CORES), .IW(IW)) u_picker (
        .req    (bus.core_req),
        .ptr    (ptr_r),
        .winner (win_oh_s),
        .idx    (win_idx_s),
        .valid  (win_valid_s)
    );

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            ptr_r       <= '0;
            owner_r     <= '0;
            owner_oh_r  <= '0;
            cnt_r       <= '0;
            gnt_r       <= '0;
            rdata_r     <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_we_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (win_valid_s) begin
                        state_r     <= S_ISSUE;
                        owner_r     <= win_idx_s;
                        owner_oh_r  <= win_oh_s;
                        mem_addr_r  <= bus.core_addr[win_idx_s*ADDR_W +: ADDR_W];
                        mem_wdata_r <= bus.core_wdata[win_idx_s*DATA_W +: DATA_W];
                        mem_we_r    <= bus.core_we[win_idx_s];
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= S_IDLE;
                        busy_r      <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    // mem_we_r still holds the latched write select here.
                    mem_we_r <= 1'b0;
                    cnt_r    <= CW'(RD_LAT);
                    if (mem_we_r) begin
                        state_r <= S_DONE;
                        gnt_r   <= owner_oh_r;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        rdata_r <= bus.mem_rdata;
                        gnt_r   <= owner_oh_r;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_DONE: begin
                    gnt_r   <= '0;
                    ptr_r   <= (owner_r == IW'(NUM_CORES - 1)) ? '0 : owner_r + IW'(1);
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    gnt_r    <= '0;
                    mem_we_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.core_gnt   = gnt_r;
    assign bus.core_rdata = rdata_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.busy       = busy_r;

endmodule
